mult_div: RTL and testbench

Sequential signed multiply/divide unit that produces the HI and LO results consumed by the CPU datapath's HI and LO registers for `mult` and `div`. The control FSM pulses `start` with operands taken from A and B. It holds the machine in a wait state while `busy` is high and loads HI and LO on `done`. One operation is in flight at a time. Results are held stable until the next operation completes.

---
 rtl/mult_div.sv | 191 +++++++++++++++++++
 tb/tb_mult_div.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// mult_div: sequential signed multiply/divide unit feeding the HI/LO registers.
//   Multiply uses radix-2 Booth (one step per cycle); divide uses restoring
//   division on magnitudes with a final sign fix. Latency is WIDTH+1 edges.
// Ports:
//   clk, reset (async, active-low)
//   start, op (0=mult, 1=div), a, b : request, sampled only in IDLE
//   hi, lo   : results (mult: product halves; div: remainder, quotient)
//   busy     : operation in flight
//   done     : one-cycle pulse, hi/lo updated
//   div_zero : one-cycle pulse on divide-by-zero trap
// Build option: MULT_DIV_DIVZERO_TRAP_EN enables the divide-by-zero trap;
//   when undefined, div_zero is tied low and x/0 returns lo=all ones, hi=a.
module mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             op_r, op_n;
    logic [WIDTH-1:0] a_r, a_n;
    logic             b_neg, b_neg_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH:0]   dvs, dvs_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             busy_n, done_n;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   shifted;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
    logic             dz_r, dz_n;
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_r  <= 1'b0;
            a_r   <= '0;
            b_neg <= 1'b0;
            acc   <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
            dz_r  <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_r  <= op_n;
            a_r   <= a_n;
            b_neg <= b_neg_n;
            acc   <= acc_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dvs   <= dvs_n;
            hi    <= hi_n;
            lo    <= lo_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
            dz_r  <= dz_n;
`endif
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_n      = op_r;
        a_n       = a_r;
        b_neg_n   = b_neg;
        acc_n     = acc;
        quo_n     = quo;
        rem_n     = rem;
        dvs_n     = dvs;
        hi_n      = hi;
        lo_n      = lo;
        busy_n    = busy;
        done_n    = 1'b0;
        booth_sum = '0;
        shifted   = '0;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
        dz_n      = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    op_n    = op;
                    a_n     = a;
                    b_neg_n = b[WIDTH-1];
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    acc_n   = {WIDTH'(0), b, 1'b0};
                    // Unsigned W-bit negation gives the correct magnitude, even for the most negative value
                    quo_n   = a[WIDTH-1] ? WIDTH'(-a) : a;
                    rem_n   = '0;
                    dvs_n   = {1'b0, (b[WIDTH-1] ? WIDTH'(-b) : b)};
                    state_n = op ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                // Add/subtract with one guard bit so the arithmetic shift keeps the true sign
                case (acc[1:0])
                    2'b01:   booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]} + {a_r[WIDTH-1], a_r};
                    2'b10:   booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]} - {a_r[WIDTH-1], a_r};
                    default: booth_sum = {acc[ACC_W-1], acc[ACC_W-1:WIDTH+1]};
                endcase
                acc_n = {booth_sum, acc[WIDTH:1]};
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) state_n = S_FIX;
            end
            S_DIV: begin
                // Restoring step: shift in next dividend bit, subtract divisor if it fits
                shifted = {rem, quo[WIDTH-1]};
                if (shifted >= dvs) begin
                    rem_n = WIDTH'(shifted - dvs);
                    quo_n = {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem_n = WIDTH'(shifted);
                    quo_n = {quo[WIDTH-2:0], 1'b0};
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) state_n = S_FIX;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
                if ((cnt == '0) && (dvs == '0)) begin
                    state_n = S_IDLE;
                    busy_n  = 1'b0;
                    dz_n    = 1'b1;
                end
`endif
            end
            S_FIX: begin
                if (op_r) begin
`ifdef MULT_DIV_DIVZERO_TRAP_EN
                    lo_n = (a_r[WIDTH-1] ^ b_neg) ? WIDTH'(-quo) : quo;
                    hi_n = a_r[WIDTH-1] ? WIDTH'(-rem) : rem;
`else
                    if (dvs == '0) begin
                        lo_n = '1;
                        hi_n = a_r;
                    end else begin
                        lo_n = (a_r[WIDTH-1] ^ b_neg) ? WIDTH'(-quo) : quo;
                        hi_n = a_r[WIDTH-1] ? WIDTH'(-rem) : rem;
                    end
`endif
                end else begin
                    {hi_n, lo_n} = acc[ACC_W-1:1];
                end
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

`ifdef MULT_DIV_DIVZERO_TRAP_EN
    assign div_zero = dz_r;
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div (WIDTH=32): directed table, random ops
// against an arithmetic model, and hand-written timing corner sequences.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset, start, op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mult_div #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, truncating division
    function automatic void model(input logic o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o) begin
            p  = sx * sy;
            eh = p[63:32];
            el = p[31:0];
        end else if (y == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = x;
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = r[31:0];
            el = q[31:0];
        end
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for done/div_zero
    task automatic do_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output logic sd, output logic sz,
                         output logic busy_ok, output logic stable);
        logic [31:0] ph, pl;
        @(negedge clk);
        ph = hi; pl = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;
        lat = 0; busy_ok = 1'b1; stable = 1'b1;
        while (!done && !div_zero && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            if (hi !== ph || lo !== pl) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        sd = done; sz = div_zero;
        if (busy) busy_ok = 1'b0;
    endtask

    initial begin
        int lat, gap, n;
        logic sd, sz, bok, stb, flag;
        logic [31:0] eh, el, x, y, ph, pl;
        logic o;

        vecs[0] = '{1'b0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};
        vecs[2] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[6] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{1'b1, 32'd0,         32'd5,        32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[9] = '{1'b1, 32'h8000_0000, 32'd1,        32'h0000_0000, 32'h8000_0000};

        reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_flags", {61'd0, busy, done, div_zero}, 64'd0);
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, sd, sz, bok, stb);
            chk($sformatf("vec%0d_result", i), {hi, lo}, {vecs[i].eh, vecs[i].el});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd33);
            chk($sformatf("vec%0d_busy", i), {62'd0, bok, stb}, 64'd3);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {63'd0, done}, 64'd0);
        end

        // Random ops against the model
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = (i % 4 == 0) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom;
            o = 1'($urandom_range(0, 1));
            if (o && y == 32'd0) y = 32'd3;
            model(o, x, y, eh, el);
            do_op(o, x, y, lat, sd, sz, bok, stb);
            chk($sformatf("rand%0d_op%0d_%0h_%0h", i, o, x, y), {hi, lo}, {eh, el});
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd33);
        end

        // Division by zero
        ph = hi; pl = lo;
`ifdef MULT_DIV_DIVZERO_TRAP_EN
        do_op(1'b1, 32'd5, 32'd0, lat, sd, sz, bok, stb);
        chk("dz_pulse", {62'd0, sz, sd}, 64'd2);
        chk("dz_latency", 64'(lat), 64'd1);
        chk("dz_hilo_kept", {hi, lo}, {ph, pl});
        chk("dz_busy_low", {63'd0, busy}, 64'd0);
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || div_zero || busy) flag = 1'b1;
        end
        chk("dz_quiet_after", {63'd0, flag}, 64'd0);
`else
        do_op(1'b1, 32'd5, 32'd0, lat, sd, sz, bok, stb);
        chk("dz_result", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        chk("dz_latency", 64'(lat), 64'd33);
        chk("dz_flags", {62'd0, sd, sz}, 64'd2);
`endif

        // start pulsed at E10 during a busy mult is ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'hFFFF_FFFD; b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; lat = 0;
        while (!done && lat < 100) begin
            if (lat == 9) begin start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("ign_latency", 64'(lat), 64'd33);
        chk("ign_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        flag = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy || done) flag = 1'b1;
        end
        chk("ign_not_queued", {63'd0, flag}, 64'd0);

        // start held high through done: back-to-back acceptance
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h0001_2345; b = 32'hFFFF_FFB3;
        @(posedge clk);
        @(negedge clk);
        op = 1'b1; a = 32'hFFFF_FC18; b = 32'd7;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first_latency", 64'(n), 64'd33);
        model(1'b0, 32'h0001_2345, 32'hFFFF_FFB3, eh, el);
        chk("b2b_first_result", {hi, lo}, {eh, el});
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; gap = 1;
        while (!done && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        chk("b2b_gap", 64'(gap), 64'd34);
        chk("b2b_second_result", {hi, lo}, {32'hFFFF_FFFA, 32'hFFFF_FF72});

        // Reset mid-division aborts
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'hFFFF_FFF9; b = 32'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        flag = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done || busy) flag = 1'b1;
        end
        chk("rst_no_done", {63'd0, flag}, 64'd0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, lat, sd, sz, bok, stb);
        chk("rst_after_result", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("rst_after_latency", 64'(lat), 64'd33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
